// File: rtl/des_pkg.sv
// Shared DES key-schedule definitions: shift schedule, PC-2 selection table, FSM encoding.
package des_pkg;

  localparam int KEY_W    = 56;
  localparam int HALF_W   = 28;
  localparam int SUBKEY_W = 48;
  localparam int NROUNDS  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit i is set when LS[i+1] is a double shift (LS = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1).
  localparam logic [NROUNDS-1:0] LS_TWO = 16'h7EFC;

  // PC-2 source positions, 1-based with bit 1 as the MSB of C||D.
  localparam int PC2_TAB [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x, input logic two);
    return two ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]} : {x[HALF_W-2:0], x[HALF_W-1]};
  endfunction

  function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] x, input logic two);
    return two ? {x[1:0], x[HALF_W-1:2]} : {x[0], x[HALF_W-1:1]};
  endfunction

endpackage

// File: rtl/des_pc2.sv
// DES permuted choice 2: selects 48 of the 56 C||D bits to form a round subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [KEY_W-1:0]    cd,
  output logic [SUBKEY_W-1:0] subkey
);

  for (genvar g = 0; g < SUBKEY_W; g++) begin : g_bit
    assign subkey[SUBKEY_W-1-g] = cd[KEY_W - PC2_TAB[g]];
  end

  // PC-2 discards positions 9,18,22,25,35,38,43,54.
  logic unused_bits;
  assign unused_bits = ^{cd[47], cd[38], cd[34], cd[31], cd[21], cd[18], cd[13], cd[2]};

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES subkey generator: streams K1..K16 (encrypt) or K16..K1 (decrypt) over a valid/ready handshake.
module des_key_schedule
  import des_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                e,
  input  logic [KEY_W-1:0]    k,
  output logic [SUBKEY_W-1:0] subkey,
  output logic                subkey_valid,
  input  logic                subkey_ready,
  output logic [3:0]          round,
  output logic                busy,
  output logic                done
);

  state_t            state;
  logic              enc;
  logic [HALF_W-1:0] c, d;
  logic [3:0]        ls_idx;
  logic              shift_two;

  // Encrypt advances to LS[round+2]; decrypt undoes LS[16-round] to step back one round.
  assign ls_idx    = enc ? round + 4'd1 : 4'd15 - round;
  assign shift_two = LS_TWO[ls_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      enc          <= 1'b0;
      c            <= '0;
      d            <= '0;
      round        <= 4'd0;
      subkey_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            enc          <= e;
            round        <= 4'd0;
            subkey_valid <= 1'b1;
            busy         <= 1'b1;
            state        <= RUN;
            // Decrypt starts from C0||D0, which equals C16||D16 since the shifts total 28.
            if (e) begin
              c <= rotl(k[KEY_W-1:HALF_W], 1'b0);
              d <= rotl(k[HALF_W-1:0], 1'b0);
            end else begin
              c <= k[KEY_W-1:HALF_W];
              d <= k[HALF_W-1:0];
            end
          end
        end
        RUN: begin
          if (subkey_ready) begin
            if (round == 4'd15) begin
              subkey_valid <= 1'b0;
              done         <= 1'b1;
              state        <= DONE;
            end else begin
              round <= round + 4'd1;
              if (enc) begin
                c <= rotl(c, shift_two);
                d <= rotl(d, shift_two);
              end else begin
                c <= rotr(c, shift_two);
                d <= rotr(d, shift_two);
              end
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  des_pc2 u_pc2 (
    .cd     ({c, d}),
    .subkey (subkey)
  );

endmodule
